// File: rtl/jtag_host_driver.sv
// jtag_host_driver: JTAG TAP master for SoC bring-up and simulation.
// Runs IR/DR scans on command and returns the captured TDO bits.
module jtag_host_driver #(
  parameter int ClkDiv = 4,
  parameter int MaxLen = 32,
  localparam int LenW = $clog2(MaxLen + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_ir_i,
  input  logic [LenW-1:0]   cmd_len_i,
  input  logic [MaxLen-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [MaxLen-1:0] rsp_data_o,
  output logic              jtag_tck_o,
  output logic              jtag_tms_o,
  output logic              jtag_tdi_o,
  input  logic              jtag_tdo_i,
  output logic              jtag_trst_no
);

  localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int CntW = (LenW > 3) ? LenW : 3;
  localparam logic [DivW-1:0] DivMax = DivW'(ClkDiv - 1);
  localparam logic [LenW-1:0] LenMax = LenW'(MaxLen);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_HDR,
    S_SHIFT,
    S_TAIL,
    S_RSP
  } state_t;

  state_t            state;
  logic [DivW-1:0]   div;
  logic [CntW-1:0]   cnt;
  logic [CntW-1:0]   cnt_nx;
  logic [CntW-1:0]   len_q;
  logic [CntW-1:0]   hdr_len;
  logic              ir_q;
  logic [MaxLen-1:0] data_q;
  logic [MaxLen-1:0] cap;
  logic [MaxLen-1:0] tdo_bit;
  logic [LenW-1:0]   len_c;
  logic              active;
  logic              wrap;
  logic              rise;
  logic              fall;
  logic              last_nx;
  logic              hdr_tms;

  // TCK edge strobes, header TMS pattern and clamped command length
  always_comb begin
    active  = (state != S_IDLE) && (state != S_RSP);
    wrap    = active && (div == DivMax);
    rise    = wrap && !jtag_tck_o;
    fall    = wrap && jtag_tck_o;
    cnt_nx  = cnt + CntW'(1);
    hdr_len = ir_q ? CntW'(4) : CntW'(3);
    hdr_tms = ir_q && (cnt_nx < CntW'(2));
    last_nx = (cnt_nx == len_q - CntW'(1));
    len_c   = (cmd_len_i > LenMax) ? LenMax
                                   : cmd_len_i;
    tdo_bit = MaxLen'(jtag_tdo_i) << cnt;
  end

  // TCK divider and scan sequencer; TMS/TDI move on TCK falls
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_INIT;
      div          <= '0;
      cnt          <= '0;
      len_q        <= '0;
      ir_q         <= 1'b0;
      data_q       <= '0;
      cap          <= '0;
      cmd_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= '0;
      jtag_tck_o   <= 1'b0;
      jtag_tms_o   <= 1'b1;
      jtag_tdi_o   <= 1'b0;
      jtag_trst_no <= 1'b0;
    end else begin
      jtag_trst_no <= 1'b1;
      if (active) begin
        if (wrap) begin
          div        <= '0;
          jtag_tck_o <= !jtag_tck_o;
        end else begin
          div <= div + DivW'(1);
        end
      end
      unique case (state)
        S_INIT: begin
          if (fall) begin
            if (cnt == CntW'(5)) begin
              state       <= S_IDLE;
              cnt         <= '0;
              cmd_ready_o <= 1'b1;
            end else begin
              cnt        <= cnt_nx;
              jtag_tms_o <= (cnt_nx < CntW'(5));
            end
          end
        end
        S_IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            ir_q        <= cmd_ir_i;
            len_q       <= CntW'(len_c);
            data_q      <= cmd_data_i;
            cap         <= '0;
            cnt         <= '0;
            if (len_c == '0) begin
              state       <= S_RSP;
              rsp_valid_o <= 1'b1;
              rsp_data_o  <= '0;
            end else begin
              state      <= S_HDR;
              jtag_tms_o <= 1'b1;
              jtag_tdi_o <= 1'b0;
            end
          end
        end
        S_HDR: begin
          if (fall) begin
            if (cnt_nx < hdr_len) begin
              cnt        <= cnt_nx;
              jtag_tms_o <= hdr_tms;
            end else begin
              state      <= S_SHIFT;
              cnt        <= '0;
              jtag_tms_o <= (len_q == CntW'(1));
              jtag_tdi_o <= data_q[0];
              data_q     <= data_q >> 1;
            end
          end
        end
        S_SHIFT: begin
          if (rise) begin
            cap <= cap | tdo_bit;
          end
          if (fall) begin
            if (cnt_nx < len_q) begin
              cnt        <= cnt_nx;
              jtag_tms_o <= last_nx;
              jtag_tdi_o <= data_q[0];
              data_q     <= data_q >> 1;
            end else begin
              state      <= S_TAIL;
              cnt        <= '0;
              jtag_tms_o <= 1'b1;
              jtag_tdi_o <= 1'b0;
            end
          end
        end
        S_TAIL: begin
          if (fall) begin
            if (cnt == '0) begin
              cnt        <= CntW'(1);
              jtag_tms_o <= 1'b0;
            end else begin
              state       <= S_RSP;
              cnt         <= '0;
              rsp_valid_o <= 1'b1;
              rsp_data_o  <= cap;
            end
          end
        end
        S_RSP: begin
          if (rsp_ready_i) begin
            state       <= S_IDLE;
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
